// File: rtl/md5_pkg.sv
// Shared MD5 definitions: FSM encoding, chaining-state struct, IV, round
// constants and the small bit-manipulation helpers used by the datapath.
package md5_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } state_e;

  // Four 32-bit MD5 registers, used for both the working and chaining sets.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } md5_state_t;

  localparam md5_state_t MD5_IV = '{
    a: 32'h67452301,
    b: 32'hefcdab89,
    c: 32'h98badcfe,
    d: 32'h10325476
  };

  // Additive constants, floor(|sin(j+1)| * 2^32).
  localparam logic [31:0] K_TABLE [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Rotate left by 0..31; the doubled word keeps s = 0 well defined.
  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] t;
    t = {x, x} << s;
    return t[63:32];
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Per-step rotate amount: four amounts per round, cycling with j mod 4.
  function automatic logic [4:0] shift_amt(input logic [5:0] j);
    logic [4:0] s;
    s = 5'd0;
    case (j[5:4])
      2'd0: case (j[1:0]) 2'd0: s = 5'd7; 2'd1: s = 5'd12; 2'd2: s = 5'd17; default: s = 5'd22; endcase
      2'd1: case (j[1:0]) 2'd0: s = 5'd5; 2'd1: s = 5'd9;  2'd2: s = 5'd14; default: s = 5'd20; endcase
      2'd2: case (j[1:0]) 2'd0: s = 5'd4; 2'd1: s = 5'd11; 2'd2: s = 5'd16; default: s = 5'd23; endcase
      default: case (j[1:0]) 2'd0: s = 5'd6; 2'd1: s = 5'd10; 2'd2: s = 5'd15; default: s = 5'd21; endcase
    endcase
    return s;
  endfunction

  // Message word index g for step j; 4-bit arithmetic gives the mod 16.
  function automatic logic [3:0] msg_index(input logic [5:0] j);
    logic [3:0] jj;
    logic [3:0] g;
    jj = j[3:0];
    case (j[5:4])
      2'd0:    g = jj;
      2'd1:    g = jj * 4'd5 + 4'd1;
      2'd2:    g = jj * 4'd3 + 4'd5;
      default: g = jj * 4'd7;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/md5_step.sv
// One MD5 step, purely combinational: selects the round function, the
// message word index and the K/S constants, and produces the next a..d.
module md5_step
  import md5_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [5:0]  step,
  input  logic [31:0] m_g,
  output logic [3:0]  g_idx,
  output logic [31:0] a_next,
  output logic [31:0] b_next,
  output logic [31:0] c_next,
  output logic [31:0] d_next
);

  logic [31:0] f;
  logic [31:0] sum;

  // Round function, mixing sum and register rotation for this step.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    f      = 32'h0;
    g_idx  = msg_index(step);
    case (step[5:4])
      2'd0:    f = (b & c) | (~b & d);
      2'd1:    f = (d & b) | (~d & c);
      2'd2:    f = b ^ c ^ d;
      default: f = c ^ (b | ~d);
    endcase
    sum    = a + f + K_TABLE[step] + m_g;
    a_next = d;
    b_next = b + rotl32(sum, shift_amt(step));
    c_next = b;
    d_next = c;
  end

endmodule

// File: rtl/md5_compress.sv
// Iterative MD5 compression: captures one 512-bit block, runs 64 steps at
// one per clock, folds the result into the chaining state, and presents the
// running digest in canonical byte order.
module md5_compress
  import md5_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init,
  input  logic         start,
  input  logic [0:511] block,
  output logic         busy,
  output logic         done,
  output logic [127:0] digest
);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] msg_q [16];
  logic [31:0] msg_d [16];
  md5_state_t  work_q, work_d;
  md5_state_t  chain_q, chain_d;

  logic        idle;
  logic [3:0]  g_idx;
  md5_state_t  step_out;

  assign idle = (state_q == ST_IDLE);

  md5_step u_step (
    .a      (work_q.a),
    .b      (work_q.b),
    .c      (work_q.c),
    .d      (work_q.d),
    .step   (cnt_q),
    .m_g    (msg_q[g_idx]),
    .g_idx  (g_idx),
    .a_next (step_out.a),
    .b_next (step_out.b),
    .c_next (step_out.c),
    .d_next (step_out.d)
  );

  // Sequencing: IDLE -> ROUND (64 steps) -> FINAL -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ROUND;
          cnt_d   = 6'd0;
        end
      end
      ST_ROUND: begin
        // 63 + 1 wraps to 0 exactly on the hand-off to FINAL.
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd63) state_d = ST_FINAL;
      end
      ST_FINAL: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Chaining state: IV load when idle, feed-forward add in FINAL.
  always_comb begin
    chain_d = chain_q;
    if (idle && init) begin
      chain_d = MD5_IV;
    end else if (state_q == ST_FINAL) begin
      chain_d.a = chain_q.a + work_q.a;
      chain_d.b = chain_q.b + work_q.b;
      chain_d.c = chain_q.c + work_q.c;
      chain_d.d = chain_q.d + work_q.d;
    end
  end

  // Working registers and block capture; init+start seeds from the IV.
  always_comb begin
    work_d = work_q;
    msg_d  = msg_q;
    if (idle && start) begin
      work_d = init ? MD5_IV : chain_q;
      for (int i = 0; i < 16; i++) begin
        msg_d[i] = {block[8*(4*i+3) +: 8], block[8*(4*i+2) +: 8],
                    block[8*(4*i+1) +: 8], block[8*(4*i)   +: 8]};
      end
    end else if (state_q == ST_ROUND) begin
      work_d = step_out;
    end
  end

  // Control and chaining registers, cleared to IDLE / IV on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      chain_q <= MD5_IV;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chain_q <= chain_d;
    end
  end

  // Word buffer and working registers: always written before being read.
  always_ff @(posedge clk) begin
    // NOTE: data-only storage is deliberately left without reset.
    msg_q  <= msg_d;
    work_q <= work_d;
  end

  assign busy   = !idle;
  assign done   = (state_q == ST_FINAL);
  assign digest = {bswap32(chain_q.a), bswap32(chain_q.b),
                   bswap32(chain_q.c), bswap32(chain_q.d)};

endmodule

// File: tb/tb_md5_compress.sv
// Self-checking bench for md5_compress against a behavioural MD5 model.
module tb_md5_compress;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         init = 1'b0;
  logic         start = 1'b0;
  logic [0:511] block = '0;
  logic         busy;
  logic         done;
  logic [127:0] digest;

  always #5 clk = ~clk;

  md5_compress dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (init),
    .start  (start),
    .block  (block),
    .busy   (busy),
    .done   (done),
    .digest (digest)
  );

  int n_checks = 0;
  int n_err    = 0;

  int unsigned k_tb [64];
  int unsigned chain [4];
  int          s_tab [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
  localparam logic [127:0] IV_DIGEST = 128'h0123456789abcdeffedcba9876543210;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rol(input logic [31:0] x, input int s);
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [31:0] bsw(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  task automatic model_iv();
    chain[0] = 32'h67452301;
    chain[1] = 32'hefcdab89;
    chain[2] = 32'h98badcfe;
    chain[3] = 32'h10325476;
  endtask

  // Textbook MD5 compression of one block into the model chaining state.
  task automatic model_block(input logic [0:511] blk);
    logic [31:0] m [16];
    logic [31:0] a, b, c, d, f, t;
    int g;
    for (int i = 0; i < 16; i++)
      m[i] = {blk[8*(4*i+3) +: 8], blk[8*(4*i+2) +: 8], blk[8*(4*i+1) +: 8], blk[8*(4*i) +: 8]};
    a = chain[0]; b = chain[1]; c = chain[2]; d = chain[3];
    for (int j = 0; j < 64; j++) begin
      if (j < 16)      begin f = (b & c) | (~b & d); g = j; end
      else if (j < 32) begin f = (d & b) | (~d & c); g = (5 * j + 1) % 16; end
      else if (j < 48) begin f = b ^ c ^ d;          g = (3 * j + 5) % 16; end
      else             begin f = c ^ (b | ~d);       g = (7 * j) % 16; end
      t = d;
      d = c;
      c = b;
      b = b + rol(a + f + k_tb[j] + m[g], s_tab[(j / 16) * 4 + (j % 4)]);
      a = t;
    end
    chain[0] += a; chain[1] += b; chain[2] += c; chain[3] += d;
  endtask

  function automatic logic [127:0] model_digest();
    return {bsw(chain[0]), bsw(chain[1]), bsw(chain[2]), bsw(chain[3])};
  endfunction

  // One block transaction with latency, busy/done and digest checks.
  task automatic run_block(input logic [0:511] blk, input bit with_init, input string tag);
    int n;
    block = blk;
    init  = with_init;
    start = 1'b1;
    tick();
    start = 1'b0;
    init  = 1'b0;
    block = {16{$urandom()}};
    check({tag, "_busy_c1"}, {127'd0, busy}, 128'd1);
    n = 1;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 128'd65);
    check({tag, "_busy_at_done"}, {127'd0, busy}, 128'd1);
    tick();
    check({tag, "_idle_after"}, {126'd0, busy, done}, 128'd0);
    if (with_init) model_iv();
    model_block(blk);
    check({tag, "_digest"}, digest, model_digest());
  endtask

  function automatic logic [7:0] digit(input int i);
    return (i % 10 == 9) ? 8'h30 : 8'(8'h31 + i % 10);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:511] blk;
    real v;
    int dones;

    for (int i = 0; i < 64; i++) begin
      v = $sin(real'(i + 1));
      if (v < 0.0) v = -v;
      k_tb[i] = 32'(longint'($floor(v * 4294967296.0)));
    end
    model_iv();

    // Reset state.
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_digest", digest, IV_DIGEST);
    check("reset_busy", {127'd0, busy}, 128'd0);
    check("reset_done", {127'd0, done}, 128'd0);

    // init alone: no busy/done.
    init = 1'b1;
    tick();
    init = 1'b0;
    check("init_only_flags", {126'd0, busy, done}, 128'd0);
    check("init_only_digest", digest, IV_DIGEST);

    // Empty message.
    blk = '0;
    blk[0 +: 8] = 8'h80;
    run_block(blk, 1'b1, "empty");
    check("empty_known", digest, 128'hd41d8cd98f00b204e9800998ecf8427e);

    // "abc".
    blk = '0;
    blk[0 +: 8] = 8'h61; blk[8 +: 8] = 8'h62; blk[16 +: 8] = 8'h63; blk[24 +: 8] = 8'h80;
    blk[8*56 +: 8] = 8'h18;
    run_block(blk, 1'b1, "abc");
    check("abc_known", digest, 128'h900150983cd24fb0d6963f7d28e17f72);

    // Two-block 80-byte message.
    for (int i = 0; i < 64; i++) blk[8*i +: 8] = digit(i);
    run_block(blk, 1'b1, "two_b1");
    blk = '0;
    for (int i = 0; i < 16; i++) blk[8*i +: 8] = digit(64 + i);
    blk[8*16 +: 8] = 8'h80;
    blk[8*56 +: 8] = 8'h80;
    blk[8*57 +: 8] = 8'h02;
    run_block(blk, 1'b0, "two_b2");
    check("two_known", digest, 128'h57edf4a22be3c955ac49da2e2107b67a);

    // Random chained blocks.
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 16; w++) blk[32*w +: 32] = $urandom();
      run_block(blk, (r == 0), $sformatf("rand%0d", r));
    end

    // start/init pulsed while busy must be ignored.
    for (int w = 0; w < 16; w++) blk[32*w +: 32] = $urandom();
    block = blk;
    start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int n = 1; n < 76; n++) begin
      if (n == 10 || n == 40) begin
        start = 1'b1;
        init  = 1'b1;
        block = {16{$urandom()}};
      end
      tick();
      start = 1'b0;
      init  = 1'b0;
      if (done) dones++;
    end
    model_block(blk);
    check("perturb_done_count", dones, 128'd1);
    check("perturb_digest", digest, model_digest());

    // Reset mid-block, then rerun "abc" from the IV without init.
    for (int w = 0; w < 16; w++) blk[32*w +: 32] = $urandom();
    block = blk;
    start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int n = 1; n < 30; n++) begin
      tick();
      if (done) dones++;
    end
    check("rst_no_early_done", dones, 128'd0);
    rst_n = 1'b0;
    #1;
    check("rst_digest_iv", digest, IV_DIGEST);
    check("rst_flags", {126'd0, busy, done}, 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    model_iv();
    blk = '0;
    blk[0 +: 8] = 8'h61; blk[8 +: 8] = 8'h62; blk[16 +: 8] = 8'h63; blk[24 +: 8] = 8'h80;
    blk[8*56 +: 8] = 8'h18;
    run_block(blk, 1'b0, "abc_rerun");
    check("abc_rerun_known", digest, 128'h900150983cd24fb0d6963f7d28e17f72);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
